// File: rtl/collision_detect.sv
// Pac-Man map lookup: classifies the proposed next tile and consumes any pill there.
// Latency: coordinates sampled at edge k give collision_type and pill_count after edge k.
// Backpressure: none; one lookup per clock, and the caller holds coordinates as long as needed.
//
// Ports:
//   CLOCK_50       - sole clock, rising edge
//   reset          - synchronous, active-low; restores the pill map and clears outputs
//   next_pacman_x  - proposed tile x (0..MAP_W-1 valid, anything else is out of bounds)
//   next_pacman_y  - proposed tile y (0..MAP_H-1 valid, anything else is out of bounds)
//   collision_type - registered class: 0000 empty, 0001 wall/OOB, 0010 pill, 0100 power pellet
//   pill_count     - running score, wraps modulo 2^33
//
// Optional feature macro: COLLISION_POWER_PELLET_EN
//   defined   -> the four inner corner tiles are power pellets (0100, worth 5)
//   undefined -> those tiles are ordinary pills (0010, worth 1); 0100 is never produced

module collision_detect #(
  parameter int MAP_W   = 40,
  parameter int MAP_H   = 30,
  parameter int START_X = 20,
  parameter int START_Y = 20
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  output logic [3:0]  collision_type,
  output logic [32:0] pill_count
);

  localparam int N_TILES = MAP_W * MAP_H;
  localparam int IDX_W   = $clog2(N_TILES);

  localparam logic [3:0] TYPE_EMPTY  = 4'b0000;
  localparam logic [3:0] TYPE_WALL   = 4'b0001;
  localparam logic [3:0] TYPE_PILL   = 4'b0010;
  localparam logic [3:0] TYPE_PELLET = 4'b0100;

  // Static walls for an in-bounds tile: the border ring plus a lattice of
  // isolated blocks wherever both coordinates are 2 mod 4.
  function automatic logic tile_is_wall(input int x, input int y);
    return (x == 0) || (x == MAP_W - 1) || (y == 0) || (y == MAP_H - 1) ||
           ((x % 4 == 2) && (y % 4 == 2));
  endfunction

  // Pill map as it stands after reset: a pill on every open tile except spawn.
  function automatic logic [N_TILES-1:0] build_reset_map();
    logic [N_TILES-1:0] m;
    m = '0;
    for (int y = 0; y < MAP_H; y++) begin
      for (int x = 0; x < MAP_W; x++) begin
        if (!tile_is_wall(x, y) && !(x == START_X && y == START_Y)) begin
          m[y * MAP_W + x] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  localparam logic [N_TILES-1:0] RESET_MAP = build_reset_map();

  logic [N_TILES-1:0] pill_map;

  int               xi;
  int               yi;
  logic             in_bounds;
  logic             is_wall;
  logic             is_pellet;
  logic [IDX_W-1:0] lookup_idx;
  logic             pill_here;
  logic             eat;
  logic [3:0]       type_nxt;
  logic [32:0]      pill_add;

  always_comb begin
    xi         = int'(next_pacman_x);
    yi         = int'(next_pacman_y);
    in_bounds  = (xi < MAP_W) && (yi < MAP_H);
    is_wall    = !in_bounds || tile_is_wall(xi, yi);
    // Out-of-bounds coordinates never reach the map; park the index at 0.
    lookup_idx = in_bounds ? IDX_W'(yi * MAP_W + xi) : '0;
    pill_here  = in_bounds && pill_map[lookup_idx];
`ifdef COLLISION_POWER_PELLET_EN
    is_pellet  = ((xi == 1) || (xi == MAP_W - 2)) && ((yi == 1) || (yi == MAP_H - 2));
`else
    is_pellet  = 1'b0;
`endif
  end

  // Priority: wall/OOB, then a present pill, then empty.
  always_comb begin
    type_nxt = TYPE_EMPTY;
    eat      = 1'b0;
    pill_add = '0;
    if (is_wall) begin
      type_nxt = TYPE_WALL;
    end else if (pill_here) begin
      eat = 1'b1;
      if (is_pellet) begin
        type_nxt = TYPE_PELLET;
        pill_add = 33'd5;
      end else begin
        type_nxt = TYPE_PILL;
        pill_add = 33'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      collision_type <= TYPE_EMPTY;
      pill_count     <= '0;
      pill_map       <= RESET_MAP;
    end else begin
      collision_type <= type_nxt;
      pill_count     <= pill_count + pill_add;
      // Clearing the bit on the same edge makes a held coordinate read empty next cycle.
      if (eat) begin
        pill_map[lookup_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_collision_detect.sv
module tb_collision_detect;

  logic        CLOCK_50;
  logic        reset;
  logic [5:0]  next_pacman_x;
  logic [4:0]  next_pacman_y;
  logic [3:0]  collision_type;
  logic [32:0] pill_count;

  int vectors;
  int miscompares;

  collision_detect dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .next_pacman_x  (next_pacman_x),
    .next_pacman_y  (next_pacman_y),
    .collision_type (collision_type),
    .pill_count     (pill_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

`ifdef COLLISION_POWER_PELLET_EN
  localparam logic [3:0] CORNER_TYPE = 4'b0100;
  localparam int         CORNER_ADD  = 5;
`else
  localparam logic [3:0] CORNER_TYPE = 4'b0010;
  localparam int         CORNER_ADD  = 1;
`endif

  // Present coordinates for one edge and settle just after it.
  task automatic step(input int x, input int y);
    next_pacman_x = 6'(x);
    next_pacman_y = 5'(y);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    next_pacman_x = 6'd20;
    next_pacman_y = 5'd20;
    pulse_reset();
    vectors++;
    if (collision_type !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_type got %b exp 0000", collision_type);
    end
    vectors++;
    if (pill_count !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d exp 0", pill_count);
    end
  endtask

  task automatic test_pill_hold();
    logic [3:0] exp_t [3];
    exp_t = '{4'b0010, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      step(20, 19);
      vectors++;
      if (collision_type !== exp_t[i] || pill_count !== 33'd1) begin
        miscompares++;
        $display("FAIL pill_hold[%0d] got type %b count %0d exp type %b count 1",
                 i, collision_type, pill_count, exp_t[i]);
      end
    end
  endtask

  task automatic test_walls();
    int xs [9];
    int ys [9];
    xs = '{0, 39, 63, 20, 2, 20, 10, 40, 30};
    ys = '{5, 10, 20, 31, 2, 29, 6, 5, 30};
    for (int i = 0; i < 9; i++) begin
      step(xs[i], ys[i]);
      vectors++;
      if (collision_type !== 4'b0001 || pill_count !== 33'd1) begin
        miscompares++;
        $display("FAIL wall(%0d,%0d) got type %b count %0d exp type 0001 count 1",
                 xs[i], ys[i], collision_type, pill_count);
      end
    end
  endtask

  task automatic test_spawn();
    int         xs [3];
    logic [3:0] et [3];
    logic [32:0] ec [3];
    pulse_reset();
    xs = '{20, 21, 21};
    et = '{4'b0000, 4'b0010, 4'b0000};
    ec = '{33'd0, 33'd1, 33'd1};
    for (int i = 0; i < 3; i++) begin
      step(xs[i], 20);
      vectors++;
      if (collision_type !== et[i] || pill_count !== ec[i]) begin
        miscompares++;
        $display("FAIL spawn[%0d] (%0d,20) got type %b count %0d exp type %b count %0d",
                 i, xs[i], collision_type, pill_count, et[i], ec[i]);
      end
    end
  endtask

  task automatic test_corner();
    // Count is 1 on entry from the spawn scenario.
    step(1, 1);
    vectors++;
    if (collision_type !== CORNER_TYPE || pill_count !== 33'(1 + CORNER_ADD)) begin
      miscompares++;
      $display("FAIL corner(1,1) got type %b count %0d exp type %b count %0d",
               collision_type, pill_count, CORNER_TYPE, 1 + CORNER_ADD);
    end
    step(38, 28);
    vectors++;
    if (collision_type !== CORNER_TYPE || pill_count !== 33'(1 + 2 * CORNER_ADD)) begin
      miscompares++;
      $display("FAIL corner(38,28) got type %b count %0d exp type %b count %0d",
               collision_type, pill_count, CORNER_TYPE, 1 + 2 * CORNER_ADD);
    end
    step(1, 1);
    vectors++;
    if (collision_type !== 4'b0000 || pill_count !== 33'(1 + 2 * CORNER_ADD)) begin
      miscompares++;
      $display("FAIL corner_again got type %b count %0d exp type 0000 count %0d",
               collision_type, pill_count, 1 + 2 * CORNER_ADD);
    end
  endtask

  task automatic test_reset_restore();
    pulse_reset();
    step(20, 19);
    step(20, 19);
    pulse_reset();
    vectors++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd0) begin
      miscompares++;
      $display("FAIL midplay_reset got type %b count %0d exp type 0000 count 0",
               collision_type, pill_count);
    end
    step(20, 19);
    vectors++;
    if (collision_type !== 4'b0010 || pill_count !== 33'd1) begin
      miscompares++;
      $display("FAIL restored_pill got type %b count %0d exp type 0010 count 1",
               collision_type, pill_count);
    end
  endtask

  task automatic test_reset_wins();
    next_pacman_x = 6'd22;
    next_pacman_y = 5'd21;
    pulse_reset();
    vectors++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd0) begin
      miscompares++;
      $display("FAIL reset_wins got type %b count %0d exp type 0000 count 0",
               collision_type, pill_count);
    end
    step(22, 21);
    vectors++;
    if (collision_type !== 4'b0010 || pill_count !== 33'd1) begin
      miscompares++;
      $display("FAIL after_reset_wins got type %b count %0d exp type 0010 count 1",
               collision_type, pill_count);
    end
  endtask

  task automatic test_back_to_back();
    int          xs [6];
    int          ys [6];
    logic [3:0]  et [6];
    logic [32:0] ec [6];
    // Entry count 1. (5,7) and (7,5) distinguish row from column indexing.
    xs = '{3, 4, 5, 3, 5, 7};
    ys = '{3, 3, 3, 3, 7, 5};
    et = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    ec = '{33'd2, 33'd3, 33'd4, 33'd4, 33'd5, 33'd6};
    for (int i = 0; i < 6; i++) begin
      step(xs[i], ys[i]);
      vectors++;
      if (collision_type !== et[i] || pill_count !== ec[i]) begin
        miscompares++;
        $display("FAIL b2b(%0d,%0d) got type %b count %0d exp type %b count %0d",
                 xs[i], ys[i], collision_type, pill_count, et[i], ec[i]);
      end
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    next_pacman_x = 6'd20;
    next_pacman_y = 5'd20;
    #1;
    test_reset();
    test_pill_hold();
    test_walls();
    test_spawn();
    test_corner();
    test_reset_restore();
    test_reset_wins();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
